// File: rtl/ctrl_reg_readback_seq_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_reg_readback_seq_pkg
// Shared definitions for the register-window readback sequencers (control
// register file and DAQ RAM variants).
//   - default parameter values
//   - FSM state encoding (state_t)
//   - nb_f(): number of UART bytes per register word
// -----------------------------------------------------------------------------
package ctrl_reg_readback_seq_pkg;

   localparam int DEF_ADDR_WIDTH  = 6;
   localparam int DEF_N_CTRL_REGS = 64;
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_BYTE_WIDTH  = 8;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_WAITLO  = 3'd3,
      ST_PRESENT = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   // Bytes per register word; DATA_WIDTH is an integer multiple of BYTE_WIDTH.
   function automatic int nb_f(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/ctrl_reg_readback_seq_if.sv
// -----------------------------------------------------------------------------
// ctrl_reg_readback_seq_if
// Bundles the control, register-file read port and UART handshake signals of
// the readback sequencer.
//   master : the sequencer (drives rd_addr, tx_data, tx_data_ready, tx_complete,
//            tx_cnt, range_err)
//   slave  : the environment (drives tx_en, start_addr, end_addr, rd_data,
//            tx_data_loaded)
// -----------------------------------------------------------------------------
interface ctrl_reg_readback_seq_if
   import ctrl_reg_readback_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
);
   logic                  tx_en;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH-1:0] end_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [BYTE_WIDTH-1:0] tx_data;
   logic                  tx_data_ready;
   logic                  tx_data_loaded;
   logic                  tx_complete;
   logic [ADDR_WIDTH-1:0] tx_cnt;
   logic                  range_err;

   modport master (
      input  tx_en, start_addr, end_addr, rd_data, tx_data_loaded,
      output rd_addr, tx_data, tx_data_ready, tx_complete, tx_cnt, range_err
   );

   modport slave (
      output tx_en, start_addr, end_addr, rd_data, tx_data_loaded,
      input  rd_addr, tx_data, tx_data_ready, tx_complete, tx_cnt, range_err
   );
endinterface

// File: rtl/ctrl_reg_readback_seq_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Single-bit synchroniser: STAGES flops with asynchronous active-low reset.
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset (chain cleared to 0)
//   d_i    in  asynchronous input
//   q_o    out synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_bit
   import ctrl_reg_readback_seq_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
)(
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;

   // Flop chain; bit 0 is the metastability-catching stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/ctrl_reg_readback_seq.sv
// -----------------------------------------------------------------------------
// ctrl_reg_readback_seq
// Walks the inclusive register window [start_addr .. end_addr] (wrapping from
// N_CTRL_REGS-1 to 0), reads each register through a 1-cycle-latency port and
// sends it MSB byte first over a ready/loaded UART handshake.
//   clk    in  40 MHz clock
//   rst_n  in  asynchronous active-low reset
//   bus    master modport:
//          tx_en, start_addr, end_addr, rd_data, tx_data_loaded (in)
//          rd_addr, tx_data, tx_data_ready, tx_complete, tx_cnt, range_err (out)
// tx_data_loaded comes from the baud domain and is only used after the
// synchroniser (ld_s). All outputs are registered.
// -----------------------------------------------------------------------------
module ctrl_reg_readback_seq
   import ctrl_reg_readback_seq_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int N_CTRL_REGS = DEF_N_CTRL_REGS,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int BYTE_WIDTH  = DEF_BYTE_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
   input logic                     clk,
   input logic                     rst_n,
   ctrl_reg_readback_seq_if.master bus
);
   localparam int NB     = nb_f(DATA_WIDTH, BYTE_WIDTH);
   localparam int BIDX_W = (NB > 1) ? $clog2(NB) : 1;
   // One extra bit so N_CTRL_REGS == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0]   N_EXT     = (ADDR_WIDTH + 1)'(N_CTRL_REGS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_CTRL_REGS - 1);
   localparam logic [BIDX_W-1:0]     LAST_BIDX = BIDX_W'(NB - 1);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [ADDR_WIDTH-1:0] end_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [BIDX_W-1:0]     byte_idx_q;
   logic [BYTE_WIDTH-1:0] tx_data_q;
   logic                  ready_q;
   logic                  complete_q;
   logic                  range_err_q;
   logic                  abort_q;

   logic                  ld_s;
   logic                  range_bad_s;
   logic                  abort_s;
   logic [ADDR_WIDTH-1:0] next_addr_s;

   sync_bit #(.STAGES(SYNC_STAGES)) u_ld_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.tx_data_loaded),
      .q_o   (ld_s)
   );

   // Window bounds check, abort request and wrapping address increment.
   always_comb begin
      range_bad_s = 1'b0;
      abort_s     = 1'b0;
      next_addr_s = '0;
      if (({1'b0, bus.start_addr} >= N_EXT) || ({1'b0, bus.end_addr} >= N_EXT)) begin
         range_bad_s = 1'b1;
      end else begin
         range_bad_s = 1'b0;
      end
      // Once an abort is seen it stays committed even if tx_en comes back.
      abort_s = !bus.tx_en || abort_q;
      if (rd_addr_q == LAST_ADDR) begin
         next_addr_s = '0;
      end else begin
         next_addr_s = rd_addr_q + ADDR_WIDTH'(1);
      end
   end

   // Readback FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rd_addr_q   <= '0;
         end_q       <= '0;
         shreg_q     <= '0;
         byte_idx_q  <= '0;
         tx_data_q   <= '0;
         ready_q     <= 1'b0;
         complete_q  <= 1'b0;
         range_err_q <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               abort_q <= 1'b0;
               if (bus.tx_en) begin
                  end_q     <= bus.end_addr;
                  rd_addr_q <= bus.start_addr;
                  if (range_bad_s) begin
                     range_err_q <= 1'b1;
                     complete_q  <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end
            end

            ST_FETCH, ST_LOAD, ST_WAITLO: begin
               if (abort_s) begin
                  // No handshake is open here; just let the UART drop loaded.
                  if (!ld_s) begin
                     rd_addr_q <= '0;
                     abort_q   <= 1'b0;
                     state_q   <= ST_IDLE;
                  end else begin
                     abort_q <= 1'b1;
                  end
               end else begin
                  case (state_q)
                     ST_FETCH: begin
                        state_q <= ST_LOAD;
                     end
                     ST_LOAD: begin
                        shreg_q    <= bus.rd_data;
                        byte_idx_q <= '0;
                        state_q    <= ST_WAITLO;
                     end
                     ST_WAITLO: begin
                        if (!ld_s) begin
                           tx_data_q <= shreg_q[DATA_WIDTH-1 -: BYTE_WIDTH];
                           ready_q   <= 1'b1;
                           state_q   <= ST_PRESENT;
                        end
                     end
                     default: begin
                        state_q <= ST_IDLE;
                     end
                  endcase
               end
            end

            ST_PRESENT: begin
               // An open handshake is always completed, abort or not.
               if (ld_s) begin
                  ready_q <= 1'b0;
                  shreg_q <= shreg_q << BYTE_WIDTH;
                  if (abort_s) begin
                     abort_q <= 1'b1;
                     state_q <= ST_WAITLO;
                  end else if (byte_idx_q != LAST_BIDX) begin
                     byte_idx_q <= byte_idx_q + BIDX_W'(1);
                     state_q    <= ST_WAITLO;
                  end else if (rd_addr_q == end_q) begin
                     complete_q <= 1'b1;
                     state_q    <= ST_DONE;
                  end else begin
                     rd_addr_q <= next_addr_s;
                     state_q   <= ST_FETCH;
                  end
               end
            end

            ST_DONE: begin
               // Re-arm only after tx_en has been seen low.
               if (!bus.tx_en) begin
                  complete_q  <= 1'b0;
                  range_err_q <= 1'b0;
                  rd_addr_q   <= '0;
                  state_q     <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rd_addr       = rd_addr_q;
   assign bus.tx_cnt        = rd_addr_q;
   assign bus.tx_data       = tx_data_q;
   assign bus.tx_data_ready = ready_q;
   assign bus.tx_complete   = complete_q;
   assign bus.range_err     = range_err_q;
endmodule

// File: tb/tb_ctrl_reg_readback_seq.sv
// -----------------------------------------------------------------------------
// tb_ctrl_reg_readback_seq
// Table of window vectors plus hand-written abort and reset sequences. A UART
// model pops expected {address, byte} pairs from a scoreboard queue each time
// the sequencer presents a byte.
// -----------------------------------------------------------------------------
module tb_ctrl_reg_readback_seq;
   localparam int AW = 7;
   localparam int NR = 64;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } exp_t;

   typedef struct {
      int   s;
      int   e;
      int   budget;
      logic exp_rerr;
      int   exp_bytes;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   ctrl_reg_readback_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .BYTE_WIDTH(8)) bus_if ();

   ctrl_reg_readback_seq #(
      .ADDR_WIDTH(AW), .N_CTRL_REGS(NR), .DATA_WIDTH(16), .BYTE_WIDTH(8), .SYNC_STAGES(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.master)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:NR-1];
   exp_t        exp_q [$];
   vec_t        vec [0:3];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_bytes = 0;
   int          viol = 0;
   logic        rdy_prev = 1'b0;
   logic [7:0]  data_prev = 8'h00;
   logic [7:0]  uart_got;
   logic [AW-1:0] uart_cnt;
   exp_t        uart_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_window(input int s, input int e);
      int n = (e >= s) ? (e - s + 1) : (NR - s + e + 1);
      int a = s;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{addr: AW'(a), data: mem[a][15:8]});
         exp_q.push_back('{addr: AW'(a), data: mem[a][7:0]});
         a = (a == NR - 1) ? 0 : a + 1;
      end
   endtask

   task automatic wait_loaded_low();
      int k = 0;
      while (bus_if.tx_data_loaded === 1'b1 && k < 200) begin
         @(posedge clk); k++;
      end
      repeat (5) @(posedge clk);
   endtask

   task automatic wait_complete(input int budget, output int cyc, output int first_rdy);
      cyc = 0;
      first_rdy = -1;
      while (bus_if.tx_complete !== 1'b1 && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (first_rdy < 0 && bus_if.tx_data_ready === 1'b1) first_rdy = cyc;
      end
   endtask

   // Register file: data valid one clock after the address.
   always @(posedge clk) begin
      bus_if.rd_data <= (bus_if.rd_addr < AW'(NR)) ? mem[bus_if.rd_addr[5:0]] : 16'hDEAD;
   end

   // Ready must never rise while loaded is high; data must hold while ready is high.
   always @(negedge clk) begin
      if (bus_if.tx_data_ready === 1'b1 && !rdy_prev && bus_if.tx_data_loaded === 1'b1) viol <= viol + 1;
      if (bus_if.tx_data_ready === 1'b1 && rdy_prev && bus_if.tx_data !== data_prev) viol <= viol + 1;
      rdy_prev  <= bus_if.tx_data_ready;
      data_prev <= bus_if.tx_data;
   end

   // UART model: loaded 5 clk after ready, held 20 clk, then dropped.
   initial begin
      bus_if.tx_data_loaded = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.tx_data_ready === 1'b1 && rst_n === 1'b1) begin
            uart_got = bus_if.tx_data;
            uart_cnt = bus_if.tx_cnt;
            n_bytes++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_byte: got data 0x%0h cnt %0d, none expected", uart_got, uart_cnt);
            end else begin
               uart_e = exp_q.pop_front();
               check("byte_data", 32'(uart_got), 32'(uart_e.data));
               check("byte_tx_cnt", 32'(uart_cnt), 32'(uart_e.addr));
            end
            repeat (5) @(posedge clk);
            #1;
            if (rst_n === 1'b1) check("data_stable_at_load", 32'(bus_if.tx_data), 32'(uart_got));
            bus_if.tx_data_loaded = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            check("ready_low_while_loaded", 32'(bus_if.tx_data_ready), 32'd0);
            bus_if.tx_data_loaded = 1'b0;
         end
      end
   end

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int first_rdy;
      int k;
      logic ok;

      rst_n = 1'b0;
      bus_if.tx_en = 1'b0;
      bus_if.start_addr = '0;
      bus_if.end_addr = '0;
      for (int i = 0; i < NR; i++) mem[i] = 16'(16'h3C00 + i * 16'h0107);
      mem[5] = 16'hA55A;

      vec[0] = '{s: 0,  e: 63, budget: 6000, exp_rerr: 1'b0, exp_bytes: 128};
      vec[1] = '{s: 62, e: 1,  budget: 600,  exp_rerr: 1'b0, exp_bytes: 8};
      vec[2] = '{s: 5,  e: 5,  budget: 200,  exp_rerr: 1'b0, exp_bytes: 2};
      vec[3] = '{s: 70, e: 3,  budget: 2,    exp_rerr: 1'b1, exp_bytes: 0};

      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 32'(bus_if.tx_data_ready), 32'd0);
      check("reset_complete", 32'(bus_if.tx_complete), 32'd0);
      check("reset_range_err", 32'(bus_if.range_err), 32'd0);
      check("reset_tx_cnt", 32'(bus_if.tx_cnt), 32'd0);
      check("reset_tx_data", 32'(bus_if.tx_data), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Table-driven windows.
      for (int v = 0; v < 4; v++) begin
         exp_q.delete();
         n_bytes = 0;
         if (!vec[v].exp_rerr) push_window(vec[v].s, vec[v].e);
         @(posedge clk); #1;
         bus_if.start_addr = AW'(vec[v].s);
         bus_if.end_addr   = AW'(vec[v].e);
         bus_if.tx_en      = 1'b1;
         wait_complete(vec[v].budget, cyc, first_rdy);
         check("complete", 32'(bus_if.tx_complete), 32'd1);
         check("range_err", 32'(bus_if.range_err), 32'(vec[v].exp_rerr));
         check("byte_count", 32'(n_bytes), 32'(vec[v].exp_bytes));
         check("queue_drained", 32'(exp_q.size()), 32'd0);
         if (!vec[v].exp_rerr) check("first_ready_latency", 32'(first_rdy), 32'd4);
         else                  check("no_ready_on_range_err", 32'(first_rdy), 32'hFFFF_FFFF);
         // tx_en held high in DONE must not restart anything.
         repeat (3) @(posedge clk); #1;
         check("done_hold", 32'(bus_if.tx_complete), 32'd1);
         bus_if.tx_en = 1'b0;
         repeat (2) @(posedge clk); #1;
         check("clr_complete", 32'(bus_if.tx_complete), 32'd0);
         check("clr_range_err", 32'(bus_if.range_err), 32'd0);
         check("clr_tx_cnt", 32'(bus_if.tx_cnt), 32'd0);
         check("clr_ready", 32'(bus_if.tx_data_ready), 32'd0);
         wait_loaded_low();
      end

      // Abort while the MSB byte of register 10 is presented.
      exp_q.delete();
      n_bytes = 0;
      push_window(8, 20);
      bus_if.start_addr = AW'(8);
      bus_if.end_addr   = AW'(20);
      bus_if.tx_en      = 1'b1;
      ok = 1'b0;
      k = 0;
      while (!ok && k < 2000) begin
         @(negedge clk);
         k++;
         if (bus_if.tx_data_ready === 1'b1 && bus_if.tx_cnt === AW'(10)) ok = 1'b1;
      end
      check("abort_reached_reg10", 32'(ok), 32'd1);
      bus_if.tx_en = 1'b0;
      repeat (60) @(posedge clk); #1;
      check("abort_bytes", 32'(n_bytes), 32'd5);
      check("abort_no_complete", 32'(bus_if.tx_complete), 32'd0);
      check("abort_ready_low", 32'(bus_if.tx_data_ready), 32'd0);
      check("abort_tx_cnt", 32'(bus_if.tx_cnt), 32'd0);
      exp_q.delete();
      n_bytes = 0;
      push_window(8, 9);
      wait_loaded_low();
      bus_if.end_addr = AW'(9);
      bus_if.tx_en    = 1'b1;
      wait_complete(1000, cyc, first_rdy);
      check("restart_complete", 32'(bus_if.tx_complete), 32'd1);
      check("restart_bytes", 32'(n_bytes), 32'd4);
      check("restart_queue", 32'(exp_q.size()), 32'd0);
      bus_if.tx_en = 1'b0;
      repeat (2) @(posedge clk);
      wait_loaded_low();

      // Asynchronous reset in PRESENT with loaded high.
      exp_q.delete();
      n_bytes = 0;
      push_window(0, 3);
      bus_if.start_addr = AW'(0);
      bus_if.end_addr   = AW'(3);
      bus_if.tx_en      = 1'b1;
      ok = 1'b0;
      k = 0;
      while (!ok && k < 500) begin
         @(negedge clk);
         k++;
         if (bus_if.tx_data_ready === 1'b1 && bus_if.tx_data_loaded === 1'b1) ok = 1'b1;
      end
      check("rst_reached_present", 32'(ok), 32'd1);
      #2;
      rst_n = 1'b0;
      bus_if.tx_en = 1'b0;
      #1;
      check("async_rst_ready", 32'(bus_if.tx_data_ready), 32'd0);
      check("async_rst_tx_data", 32'(bus_if.tx_data), 32'd0);
      check("async_rst_tx_cnt", 32'(bus_if.tx_cnt), 32'd0);
      check("async_rst_complete", 32'(bus_if.tx_complete), 32'd0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      n_bytes = 0;
      repeat (5) @(posedge clk); #1;
      check("post_rst_no_ready", 32'(bus_if.tx_data_ready), 32'd0);
      check("post_rst_loaded_still_high", 32'(bus_if.tx_data_loaded), 32'd1);
      push_window(0, 0);
      bus_if.end_addr = AW'(0);
      bus_if.tx_en    = 1'b1;
      wait_complete(500, cyc, first_rdy);
      check("post_rst_complete", 32'(bus_if.tx_complete), 32'd1);
      check("post_rst_bytes", 32'(n_bytes), 32'd2);
      bus_if.tx_en = 1'b0;
      repeat (2) @(posedge clk);
      wait_loaded_low();

      check("ready_rules", 32'(viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
